// File: rtl/fp_divsqrt_arb.sv
// Round-robin arbiter and sequencer sharing one fp_div/fp_sqrt pair between two requesters.
// Optional watchdog on the BUSY wait: define FP_DIVSQRT_WDOG_EN.

package fp_divsqrt_arb_pkg;

    typedef enum logic [1:0] {
        FP32    = 2'd0,
        FP64    = 2'd1,
        FP16    = 2'd2,
        FP16ALT = 2'd3
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    // Unrounded unit result, sized for the widest format (52b fraction + hidden + guard/round/sticky).
    typedef struct packed {
        logic        sign;
        logic [12:0] exponent;
        logic [55:0] mantissa;
        logic [4:0]  status;
    } uround_res_t;

    function automatic int unsigned fp_width(input fp_format_e fmt);
        case (fmt)
            FP64:          return 64;
            FP16, FP16ALT: return 16;
            default:       return 32;
        endcase
    endfunction

endpackage

module fp_divsqrt_arb
    import fp_divsqrt_arb_pkg::*;
#(
    parameter fp_format_e  FP_FORMAT   = FP32,
    parameter int unsigned TAG_WIDTH   = 4,
    parameter int unsigned WDOG_CYCLES = 64,
    localparam int unsigned FP_WIDTH   = fp_width(FP_FORMAT),
    localparam int unsigned URES_WIDTH = $bits(uround_res_t)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [1:0]                req_valid_i,
    output logic [1:0]                req_ready_o,
    input  logic [1:0]                req_op_i,
    input  logic [1:0][FP_WIDTH-1:0]  req_a_i,
    input  logic [1:0][FP_WIDTH-1:0]  req_b_i,
    input  logic [1:0][2:0]           req_rnd_i,
    input  logic [1:0][TAG_WIDTH-1:0] req_tag_i,
    output logic                      div_start_o,
    output logic                      sqrt_start_o,
    output logic [FP_WIDTH-1:0]       unit_a_o,
    output logic [FP_WIDTH-1:0]       unit_b_o,
    output logic [2:0]                unit_rnd_o,
    input  logic                      div_done_i,
    input  logic                      sqrt_done_i,
    input  logic [URES_WIDTH-1:0]     div_res_i,
    input  logic [URES_WIDTH-1:0]     sqrt_res_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic                      rsp_id_o,
    output logic [TAG_WIDTH-1:0]      rsp_tag_o,
    output logic [URES_WIDTH-1:0]     rsp_res_o,
    output logic                      rsp_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e     state_q;
    state_e     state_d;
    logic       prio_q;
    logic       op_q;
    logic       winner;
    logic [1:0] ready;
    logic       accept;
    logic       start_div_d;
    logic       start_sqrt_d;
    logic       unit_done;
    logic       take_res;
    logic       wdog_fire;
    logic       resp_clear;

`ifdef FP_DIVSQRT_WDOG_EN
    localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;

    logic [WDOG_W-1:0] wdog_cnt_q;
    logic              wdog_hit;
    logic              timeout_q;

    assign wdog_hit = (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1));
`endif

    // Next-state, grant and handshake decode
    always_comb begin
        state_d      = state_q;
        winner       = prio_q;
        ready        = 2'b00;
        accept       = 1'b0;
        start_div_d  = 1'b0;
        start_sqrt_d = 1'b0;
        take_res     = 1'b0;
        wdog_fire    = 1'b0;
        resp_clear   = 1'b0;
        unit_done    = op_q ? sqrt_done_i : div_done_i;

        if (!req_valid_i[prio_q]) begin
            winner = ~prio_q;
        end

        case (state_q)
            S_IDLE: begin
                if ((|req_valid_i) && !reset_i) begin
                    ready[winner] = 1'b1;
                    accept        = 1'b1;
                    start_div_d   = ~req_op_i[winner];
                    start_sqrt_d  = req_op_i[winner];
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (unit_done) begin
                    take_res = 1'b1;
                    state_d  = S_RESP;
                end
`ifdef FP_DIVSQRT_WDOG_EN
                else if (wdog_hit) begin
                    wdog_fire = 1'b1;
                    state_d   = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    resp_clear = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready_o = ready;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, start pulses and response capture
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            prio_q       <= 1'b0;
            op_q         <= 1'b0;
            div_start_o  <= 1'b0;
            sqrt_start_o <= 1'b0;
            unit_a_o     <= '0;
            unit_b_o     <= '0;
            unit_rnd_o   <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= 1'b0;
            rsp_tag_o    <= '0;
            rsp_res_o    <= '0;
        end else begin
            div_start_o  <= start_div_d;
            sqrt_start_o <= start_sqrt_d;
            if (accept) begin
                op_q       <= req_op_i[winner];
                unit_a_o   <= req_a_i[winner];
                unit_b_o   <= req_b_i[winner];
                unit_rnd_o <= req_rnd_i[winner];
                rsp_tag_o  <= req_tag_i[winner];
                rsp_id_o   <= winner;
                prio_q     <= ~winner;
            end
            if (take_res) begin
                rsp_res_o   <= op_q ? sqrt_res_i : div_res_i;
                rsp_valid_o <= 1'b1;
            end
            if (wdog_fire) begin
                rsp_res_o   <= '0;
                rsp_valid_o <= 1'b1;
            end
            if (resp_clear) begin
                rsp_valid_o <= 1'b0;
            end
        end
    end

`ifdef FP_DIVSQRT_WDOG_EN
    // Counter restarts every time BUSY is entered
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wdog_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q != S_BUSY) begin
                wdog_cnt_q <= '0;
            end else begin
                wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
            end
            if (wdog_fire) begin
                timeout_q <= 1'b1;
            end else if (resp_clear) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign rsp_timeout_o = timeout_q;
`else
    localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;

    assign rsp_timeout_o = 1'b0;
`endif

    a_one_start: assert property (@(posedge clk_i) disable iff (reset_i)
        !(div_start_o && sqrt_start_o));
    a_start_in_issue: assert property (@(posedge clk_i) disable iff (reset_i)
        (div_start_o || sqrt_start_o) |-> (state_q == S_ISSUE));
    a_ready_in_idle: assert property (@(posedge clk_i) disable iff (reset_i)
        (state_q != S_IDLE) |-> (req_ready_o == 2'b00));
    a_valid_in_resp: assert property (@(posedge clk_i) disable iff (reset_i)
        rsp_valid_o == (state_q == S_RESP));

endmodule

// File: doc/fp_divsqrt_arb.md
# fp_divsqrt_arb

Shared-resource arbiter and sequencer for the iterative FP divide and square-root units. Accepts operations from two requesters (e.g. two issue lanes), grants one at a time round-robin, and launches the selected unit with a one-cycle `start_i` pulse. It then waits for that unit's `done_o`, captures the unrounded result, and returns it with the requester's id and tag. The block sits between the issue stage and the shared `fp_div`/`fp_sqrt` pair; rounding happens downstream.

## Interface
- `FP_FORMAT`, `FP32`: operand format; sets `FP_WIDTH` via `fp_width()`.
- `TAG_WIDTH`, `4`: opaque requester tag width.
- `WDOG_CYCLES`, `64`: watchdog limit in cycles; used only with `FP_DIVSQRT_WDOG_EN`.
- `URES_WIDTH` (localparam): `$bits(uround_res_t)`.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  2  per-requester request valid.
- `req_ready_o`  out  2  per-requester grant/accept.
- `req_op_i`  in  2  per-requester op: 0 = div, 1 = sqrt.
- `req_a_i`, `req_b_i`  in  2×FP_WIDTH  packed operands; requester r occupies slice r; b is ignored for sqrt.
- `req_rnd_i`  in  2×3  per-requester `roundmode_e`.
- `req_tag_i`  in  2×TAG_WIDTH  per-requester tag.
- `div_start_o`, `sqrt_start_o`  out  1  one-cycle start pulses.
- `unit_a_o`, `unit_b_o`  out  FP_WIDTH  latched operands to both units.
- `unit_rnd_o`  out  3  latched rounding mode.
- `div_done_i`, `sqrt_done_i`  in  1  unit completion.
- `div_res_i`, `sqrt_res_i`  in  URES_WIDTH  unit `urnd_result_o`.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response accept.
- `rsp_id_o`  out  1  requester index.
- `rsp_tag_o`  out  TAG_WIDTH  echoed tag.
- `rsp_res_o`  out  URES_WIDTH  captured result.
- `rsp_timeout_o`  out  1  watchdog fired; constant 0 without the macro.

## Operation
- FSM states: IDLE, ISSUE, BUSY, RESP.
- **IDLE**
  - Winner is chosen among asserted `req_valid_i` using round-robin pointer `prio` (the favoured requester).
  - `req_ready_o[winner]` is 1 combinationally; all other ready bits are 0.
  - On valid&ready: latch op, a, b, rnd, tag and id; set `prio` to the other requester; go to ISSUE.
- **ISSUE** (exactly 1 cycle)
  - Pulse `div_start_o` or `sqrt_start_o` according to the latched op.
  - Go to BUSY.
- **BUSY**
  - Wait for the done of the selected unit only; done from the other unit is ignored.
  - On done: capture the matching `*_res_i` into `rsp_res_o`; go to RESP.
- **RESP**
  - `rsp_valid_o` = 1; all response fields are held stable until `rsp_ready_i`.
  - On `rsp_ready_i`: go to IDLE.
- `unit_a_o`, `unit_b_o` and `unit_rnd_o` hold the latched values from ISSUE through the end of BUSY.
- `req_ready_o` is 0 in ISSUE, BUSY and RESP.
- Done pulses arriving in IDLE, ISSUE or RESP are ignored.
- When both requesters are valid, the winner alternates every grant. A single requester is granted back-to-back.
- Reset, including mid-operation:
  - state → IDLE; `prio` → 0; all outputs 0.
  - Any in-flight unit result is discarded; the units share `reset_i`.

## Timing
- Accept at cycle T; start pulse at T+1; earliest done sampled at T+2.
- Done sampled at cycle D → `rsp_valid_o` from D+1.
- With `rsp_ready_i` at D+1: IDLE at D+2; the next grant can occur at D+2.
- Minimum occupancy is 3 cycles plus unit latency.
- Only one operation is ever outstanding; the two start outputs are never high together.

## Configuration
- `FP_DIVSQRT_WDOG_EN` defined:
  - A cycle counter clears on entry to BUSY.
  - If the selected done has not arrived after `WDOG_CYCLES` BUSY cycles, go to RESP with `rsp_timeout_o` = 1 and `rsp_res_o` = 0.
  - `rsp_timeout_o` clears on leaving RESP.
  - A later stray done is ignored.
- Undefined: no counter; BUSY waits indefinitely; `rsp_timeout_o` is tied to 0.

## Test plan
- Single div from requester 0: a=0x40490FDB, b=0x3F800000, tag=5, unit done 12 cycles after start → one `div_start_o` pulse at T+1; response id=0, tag=5, result equals `div_res_i`; `rsp_timeout_o`=0.
- Both requesters valid continuously with 4 ops each → grants alternate 0,1,0,1…; a second op is never granted before the prior response handshake.
- Sqrt op (req_op=1) with a stray `div_done_i` during BUSY → stray done ignored; completes only on `sqrt_done_i`.
- `rsp_ready_i` held 0 for 10 cycles in RESP → `rsp_valid_o` and all fields stable; no new `req_ready_o`.
- `reset_i` asserted mid-BUSY → next cycle IDLE, all outputs 0, `prio`=0; a late done produces no response.
- With `FP_DIVSQRT_WDOG_EN`, `WDOG_CYCLES`=8, done never asserted → response after 8 BUSY cycles with `rsp_timeout_o`=1 and result 0; without the macro, the bench sees no response.
